// File: rtl/normalize_exp.sv
// Post-add normalizer: shifts the raw sum mantissa until the hidden bit is set,
// adjusts the exponent, and presents a packed single-precision result with flags.
//
// state  | meaning
// S_IDLE | waiting for an input word; in_ready high
// S_NORM | one left shift per cycle until bit 23 is set or the exponent hits 1
// S_DONE | result and flags held until the consumer takes them
module normalize_exp (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_sign_in,
    input  logic [7:0]  i_exp_in,
    input  logic [24:0] i_mant_in,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_overflow,
    output logic        o_underflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sign;
    logic        w_sign_nxt;
    logic [7:0]  r_exp;
    logic [7:0]  w_exp_nxt;
    // The carry bit only exists at the load edge, so the working mantissa is 24 bits.
    logic [23:0] r_mant;
    logic [23:0] w_mant_nxt;
    logic [31:0] r_result;
    logic [31:0] w_result_nxt;
    logic        r_zero;
    logic        w_zero_nxt;
    logic        r_overflow;
    logic        w_overflow_nxt;
    logic        r_underflow;
    logic        w_underflow_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= 8'h00;
            r_mant      <= 24'h000000;
            r_result    <= 32'h0000_0000;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sign      <= w_sign_nxt;
            r_exp       <= w_exp_nxt;
            r_mant      <= w_mant_nxt;
            r_result    <= w_result_nxt;
            r_zero      <= w_zero_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sign_nxt      = r_sign;
        w_exp_nxt       = r_exp;
        w_mant_nxt      = r_mant;
        w_result_nxt    = r_result;
        w_zero_nxt      = r_zero;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;

        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_sign_nxt      = i_sign_in;
                    w_exp_nxt       = i_exp_in;
                    w_mant_nxt      = i_mant_in[23:0];
                    w_result_nxt    = 32'h0000_0000;
                    w_zero_nxt      = 1'b0;
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b0;
                    if (i_mant_in == 25'd0) begin
                        w_result_nxt = {i_sign_in, 31'd0};
                        w_zero_nxt   = 1'b1;
                        w_state_nxt  = S_DONE;
                    end else if ((i_exp_in == 8'hFF) ||
                                 (i_mant_in[24] && (i_exp_in >= 8'hFE))) begin
                        w_result_nxt   = {i_sign_in, 8'hFF, 23'd0};
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = S_DONE;
                    end else if (i_exp_in == 8'h00) begin
                        w_result_nxt    = {i_sign_in, 31'd0};
                        w_underflow_nxt = 1'b1;
                        w_state_nxt     = S_DONE;
                    end else if (i_mant_in[24]) begin
                        // Carry-out: shift right once here, dropping bit 0 unrounded.
                        w_mant_nxt  = i_mant_in[24:1];
                        w_exp_nxt   = i_exp_in + 8'd1;
                        w_state_nxt = S_NORM;
                    end else begin
                        w_state_nxt = S_NORM;
                    end
                end
            end

            S_NORM: begin
                if (r_mant[23]) begin
                    w_result_nxt = {r_sign, r_exp, r_mant[22:0]};
                    w_state_nxt  = S_DONE;
                end else if (r_exp == 8'd1) begin
                    w_result_nxt    = {r_sign, 31'd0};
                    w_underflow_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_mant_nxt = {r_mant[22:0], 1'b0};
                    w_exp_nxt  = r_exp - 8'd1;
                end
            end

            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: doc/normalize_exp.md
# normalize_exp

Post-add normalizer for the single-precision floating-point adder datapath. Exponent compare and alignment right-shift the smaller mantissa ahead of the adder; this block runs the other direction after the add. It takes the raw sum mantissa and the common exponent, left-shifts one bit per cycle until the hidden bit is set (or right-shifts once on carry-out), and adjusts the exponent to match. It then packs an IEEE-754 single-precision result behind a valid/ready handshake.

## Interface
- No parameters. Widths are fixed: 8-bit exponent, 25-bit mantissa, 32-bit result.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept; equals (state == IDLE).
- sign_in  in  1  sign of the sum.
- exp_in  in  8  biased common exponent, taken from the larger operand.
- mant_in  in  25  raw sum: bit24 = carry, bit23 = hidden bit, bits 22:0 = fraction.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  {sign, exp[7:0], frac[22:0]}.
- zero  out  1  result is signed zero from a zero mantissa.
- overflow  out  1  result is forced to signed infinity.
- underflow  out  1  result is flushed to signed zero because the exponent ran out.

## Operation
- States: IDLE, NORM, DONE.
- IDLE: on an edge with in_valid & in_ready, load sign_r, exp_r, mant_r and leave IDLE. The load edge applies these rules in priority order:
  - mant_in == 0: result = {sign_in, 31'b0}, zero = 1, go to DONE.
  - exp_in == 255, or (mant_in[24] & exp_in >= 254): result = {sign_in, 8'hFF, 23'b0}, overflow = 1, go to DONE.
  - exp_in == 0 with nonzero mantissa: flush to {sign_in, 31'b0}, underflow = 1, go to DONE.
  - mant_in[24] = 1: mant_r = mant_in >> 1, with bit0 truncated and no rounding; exp_r = exp_in + 1; go to NORM.
  - Otherwise: mant_r = mant_in, exp_r = exp_in, go to NORM.
- NORM, evaluated once per cycle:
  - mant_r[23] = 1: result = {sign_r, exp_r, mant_r[22:0]}, go to DONE.
  - Else if exp_r == 1: flush to {sign_r, 31'b0}, underflow = 1, go to DONE. Denormals are not produced.
  - Else: mant_r <<= 1, exp_r -= 1, stay in NORM.
- DONE: out_valid = 1. result and all flags hold stable until an edge with out_ready = 1, which returns the block to IDLE.
- Flags are mutually exclusive. All flags clear on the next accept.
- No overlap between jobs: in_ready stays 0 from the accept edge until the DONE handshake edge.
- Exponent arithmetic is 8-bit unsigned. The bounds checks above prevent any wrap-around.

## Timing
- Reset values: out_valid = 0, result = 32'h0, zero = overflow = underflow = 0, state = IDLE (so in_ready = 1).
- Reset mid-operation aborts the job immediately. The block returns to IDLE and the partial result is discarded.
- Latency, counted from the accept edge to the first cycle with out_valid high:
  - Zero, overflow and exp_in == 0 cases: 1 cycle.
  - Normalize path: 2 + k cycles, where k is the number of left shifts (0 to 23).
  - Worst case: 25 cycles.
- out_valid falls in the cycle after the handshake edge. in_ready rises in that same cycle.
- in_valid is ignored while not in IDLE. The upstream stage holds its data until it sees in_ready.
- The right-shift on carry happens only at the load edge and never costs an extra cycle.

## Test plan
- Already normalized: sign = 0, exp_in = 8'h80, mant_in = 25'h0800000 → result = 32'h40000000, all flags 0, out_valid 2 cycles after accept.
- Carry-out: exp_in = 8'h7F, mant_in = 25'h1800000 → result = 32'h40400000 (3.0), latency 2.
- Leading zeros: exp_in = 8'h85, mant_in = 25'h0000100 → 15 shifts, result = 32'h3B000000, out_valid 17 cycles after accept.
- Special values:
  - mant_in = 0, sign = 1 → result = 32'h80000000, zero = 1, latency 1.
  - exp_in = 8'hFE, mant_in[24] = 1, sign = 1 → result = 32'hFF800000, overflow = 1, latency 1.
- Underflow: exp_in = 8'h03, mant_in = 25'h0000001 → result = 32'h0, underflow = 1, out_valid 4 cycles after accept.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles in DONE → result and flags stable, in_ready = 0, a new in_valid is not accepted.
  - Drop rst_n during NORM → out_valid = 0, in_ready = 1 asynchronously. The next job completes correctly.
